// File: rtl/ma_mem_arbiter.sv
`default_nettype none
// ma_mem_arbiter: round-robin arbiter sharing one single-port data RAM
// between two 4-phase Send/Ack memory-access requesters.  Rev 1.0
module ma_mem_arbiter #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 10,
  parameter int SYNC_STAGES = 2,
  parameter int MEM_LAT     = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              send0_i,
  output logic              ack0_o,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic              we0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  output logic [DATA_W-1:0] rdata0_o,
  input  logic              send1_i,
  output logic              ack1_o,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic              we1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [1:0]        grant_o,
  output logic              busy_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam int         CNT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic [SYNC_STAGES-1:0] sync0_q, sync1_q;
  logic [1:0]             sreq, pend;
  logic                   win;

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic              gidx_q, gidx_d;
  logic              st_we_q, st_we_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        ack_q, ack_d;
  logic              mem_ce_q, mem_ce_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign sreq = {sync1_q[SYNC_STAGES-1], sync0_q[SYNC_STAGES-1]};
  assign pend = sreq & ~ack_q;

  always_comb begin
    win         = pend[1];
    if (pend == 2'b11) win = ~last_q;
    state_d     = state_q;
    last_d      = last_q;
    gidx_d      = gidx_q;
    st_we_d     = st_we_q;
    grant_d     = grant_q;
    ack_d       = ack_q;
    mem_ce_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pend != 2'b00) begin
          gidx_d      = win;
          last_d      = win;
          grant_d     = {win, ~win};
          st_we_d     = win ? we1_i : we0_i;
          mem_ce_d    = 1'b1;
          mem_we_d    = win ? we1_i : we0_i;
          mem_addr_d  = win ? addr1_i : addr0_i;
          mem_wdata_d = win ? wdata1_i : wdata0_i;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Read data is captured on the edge that closes the last wait cycle.
        if (cnt_q == '0) begin
          if (!st_we_q) begin
            if (gidx_q) rdata1_d = mem_rdata_i;
            else        rdata0_d = mem_rdata_i;
          end
          ack_d[gidx_q] = 1'b1;
          state_d       = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        if (!sreq[gidx_q]) begin
          ack_d   = 2'b00;
          grant_d = 2'b00;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync0_q     <= '0;
      sync1_q     <= '0;
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      gidx_q      <= 1'b0;
      st_we_q     <= 1'b0;
      grant_q     <= 2'b00;
      ack_q       <= 2'b00;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      cnt_q       <= '0;
    end else begin
      sync0_q     <= {sync0_q[SYNC_STAGES-2:0], send0_i};
      sync1_q     <= {sync1_q[SYNC_STAGES-2:0], send1_i};
      state_q     <= state_d;
      last_q      <= last_d;
      gidx_q      <= gidx_d;
      st_we_q     <= st_we_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ack0_o      = ack_q[0];
  assign ack1_o      = ack_q[1];
  assign rdata0_o    = rdata0_q;
  assign rdata1_o    = rdata1_q;
  assign mem_ce_o    = mem_ce_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule
`default_nettype wire
